// File: rtl/aes_spi_pkg.sv
// Shared encodings for the SPI/AES test link: key-size codes, widths,
// responder state encoding and the key-length helper.
package aes_spi_pkg;

  localparam int MSG_W = 128;

  localparam logic [1:0] SZ_128 = 2'b00;
  localparam logic [1:0] SZ_192 = 2'b01;
  localparam logic [1:0] SZ_256 = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_MSG,
    ST_RX_KEY,
    ST_CORE,
    ST_WAIT_MODE,
    ST_TX,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic [8:0] key_len(input logic [1:0] size);
    case (size)
      SZ_128:  key_len = 9'd128;
      SZ_192:  key_len = 9'd192;
      SZ_256:  key_len = 9'd256;
      default: key_len = 9'd128;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// Result shift register for the responder: parallel load, LSB-first shift,
// registered serial output that idles at 0 whenever no shift is requested.
module spi_shift_tx #(
  parameter int W = aes_spi_pkg::MSG_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         miso_o
);

  logic [W-1:0] sr_q;
  logic         miso_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      miso_q <= 1'b0;
    end else begin
      miso_q <= shift_i ? sr_q[0] : 1'b0;
      if (load_i) begin
        sr_q <= data_i;
      end else if (shift_i) begin
        sr_q <= {1'b0, sr_q[W-1:1]};
      end
    end
  end

  assign miso_o = miso_q;

endmodule

// File: rtl/spi_aes_responder.sv
// SPI-side responder: receives message + key LSB first, hands them to the AES
// core, then streams the result back on miso. Build option: SPI_AES_RESP_LOOPBACK_EN.
module spi_aes_responder #(
  parameter int MSG_W     = aes_spi_pkg::MSG_W,
  parameter int KEY_MAX_W = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 mosi,
  input  logic                 mode,
  input  logic [1:0]           size,
  output logic                 miso,
  output logic                 core_start,
  output logic [MSG_W-1:0]     core_msg,
  output logic [KEY_MAX_W-1:0] core_key,
  output logic [1:0]           core_size,
  input  logic                 core_done,
  input  logic [MSG_W-1:0]     core_result,
  output logic                 frame_err,
  output logic                 busy
);

  import aes_spi_pkg::*;

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic [MSG_W-1:0]       msg_q;
  logic [KEY_MAX_W-1:0]   key_q;
  logic [KEY_MAX_W-1:0]   key_w;
  logic                   core_start_q;
  logic [MSG_W-1:0]       core_msg_q;
  logic [KEY_MAX_W-1:0]   core_key_q;
  logic [1:0]             core_size_q;
  logic                   frame_err_q;
  logic                   key_last;
  logic                   tx_load;
  logic                   tx_shift;
  logic [MSG_W-1:0]       tx_data;

  assign key_last = ({1'b0, cnt_q} == (key_len(core_size_q) - 9'd1));

  always_comb begin
    key_w        = key_q;
    key_w[cnt_q] = mosi;
    // TX counts 1..128 after the mode edge; bit 7 marks the stream as finished.
    tx_shift = !cs && ((state_q == ST_WAIT_MODE && mode) ||
                       (state_q == ST_TX && !cnt_q[7]));
`ifdef SPI_AES_RESP_LOOPBACK_EN
    tx_load = !cs && (state_q == ST_RX_KEY) && key_last;
    tx_data = msg_q;
`else
    tx_load = !cs && (state_q == ST_CORE) && core_done;
    tx_data = core_result;
`endif
  end

`ifdef SPI_AES_RESP_LOOPBACK_EN
  logic unused_core;
  assign unused_core = ^{core_done, core_result};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      msg_q        <= '0;
      key_q        <= '0;
      core_start_q <= 1'b0;
      core_msg_q   <= '0;
      core_key_q   <= '0;
      core_size_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      if (cs) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            core_size_q <= size;
            frame_err_q <= (size == SZ_ILL);
            msg_q       <= MSG_W'(mosi);
            key_q       <= '0;
            cnt_q       <= 8'd1;
            state_q     <= (size == SZ_ILL) ? ST_ERR : ST_RX_MSG;
          end
          ST_RX_MSG: begin
            msg_q[cnt_q[6:0]] <= mosi;
            if (cnt_q == 8'd127) begin
              cnt_q   <= '0;
              state_q <= ST_RX_KEY;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_RX_KEY: begin
            key_q <= key_w;
            cnt_q <= cnt_q + 8'd1;
            if (key_last) begin
              cnt_q      <= '0;
              core_msg_q <= msg_q;
              core_key_q <= key_w;
`ifdef SPI_AES_RESP_LOOPBACK_EN
              state_q    <= ST_WAIT_MODE;
`else
              core_start_q <= 1'b1;
              state_q      <= ST_CORE;
`endif
            end
          end
          ST_CORE: begin
            if (core_done) state_q <= ST_WAIT_MODE;
          end
          ST_WAIT_MODE: begin
            if (mode) begin
              state_q <= ST_TX;
              cnt_q   <= 8'd1;
            end
          end
          ST_TX: begin
            if (cnt_q[7]) begin
              state_q <= ST_DONE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_DONE, ST_ERR: begin
            state_q <= state_q;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  spi_shift_tx #(.W(MSG_W)) u_tx (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (tx_load),
    .data_i  (tx_data),
    .shift_i (tx_shift),
    .miso_o  (miso)
  );

  assign core_start = core_start_q;
  assign core_msg   = core_msg_q;
  assign core_key   = core_key_q;
  assign core_size  = core_size_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_aes_responder.sv
// Bench for spi_aes_responder: frames are described as timelines (edge j of a frame
// carries bit j), expected outputs per edge come from those timelines.
module tb_spi_aes_responder;

  logic         clk = 1'b0;
  logic         reset, cs, mosi, mode, core_done;
  logic [1:0]   size;
  logic         miso, core_start, frame_err, busy;
  logic [127:0] core_msg, core_result;
  logic [255:0] core_key;
  logic [1:0]   core_size;

  int n_chk = 0;
  int n_fail = 0;

  logic         chk_en = 1'b0;
  logic         e_busy, e_start, e_miso, e_err;
  logic         p_busy, p_start, p_miso, p_err;
  int           e_tx = -1;
  int           p_tx = -1;
  logic [127:0] e_msg;
  logic [255:0] e_key;
  logic [1:0]   e_size;
  logic         cur_err = 1'b0;
  int           fclk = 0;
  int           start_cnt = 0;
  int           start_at = -1;
  logic [127:0] got_res;
  logic [255:0] got_key;

`ifdef SPI_AES_RESP_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_aes_responder #(.MSG_W(128), .KEY_MAX_W(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .mosi        (mosi),
    .mode        (mode),
    .size        (size),
    .miso        (miso),
    .core_start  (core_start),
    .core_msg    (core_msg),
    .core_key    (core_key),
    .core_size   (core_size),
    .core_done   (core_done),
    .core_result (core_result),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [1:0] r2();
    return 2'($urandom_range(3, 0));
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 256'(busy), 256'(e_busy));
      chk("core_start", 256'(core_start), 256'(e_start));
      chk("miso", 256'(miso), 256'(e_miso));
      chk("frame_err", 256'(frame_err), 256'(e_err));
      if (core_start) begin
        start_cnt++;
        start_at = fclk;
        got_key  = core_key;
      end
      if (e_start) begin
        chk("core_msg", 256'(core_msg), 256'(e_msg));
        chk("core_key", core_key, e_key);
        chk("core_size", 256'(core_size), 256'(e_size));
      end
      if (e_tx >= 0) got_res[e_tx[6:0]] = miso;
    end
  end

  task automatic want(input logic b, input logic st, input logic mi, input logic er, input int tx);
    p_busy = b; p_start = st; p_miso = mi; p_err = er; p_tx = tx;
  endtask

  task automatic tick(input logic c, input logic d, input logic md, input logic [1:0] sz,
                      input logic dn, input logic rs);
    cs = c; mosi = d; mode = md; size = sz; core_done = dn; reset = rs;
    @(posedge clk);
    #1;
    fclk++;
    e_busy = p_busy; e_start = p_start; e_miso = p_miso; e_err = p_err; e_tx = p_tx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      want(1'b0, 1'b0, 1'b0, cur_err, -1);
      tick(1'b1, rb(), rb(), r2(), 1'b0, 1'b0);
    end
  endtask

  task automatic run_frame(input logic [127:0] m, input logic [255:0] k, input logic [1:0] sz,
                           input logic [127:0] res, input int abort_bit, input bit toggle,
                           input int gap_done, input int gap_mode, input int rst_at);
    int kl;
    logic [127:0] txd;
    logic [1:0]   alt;
    kl  = (sz == 2'b01) ? 192 : (sz == 2'b10) ? 256 : 128;
    alt = (sz == 2'b10) ? 2'b11 : 2'b10;
    fclk = 0; start_cnt = 0; start_at = -1; got_res = '0;
    e_msg  = m;
    e_key  = (kl == 256) ? k : (k & ((256'(1) << kl) - 256'(1)));
    e_size = sz;
    cur_err = 1'b0;
    for (int j = 0; j < 128 + kl; j++) begin
      if (abort_bit >= 0 && j == 128 + abort_bit) begin
        want(1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(1'b1, rb(), rb(), r2(), 1'b0, 1'b0);
        want(1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(1'b1, rb(), rb(), r2(), 1'b1, 1'b0);
        idle(3);
        return;
      end
      want(1'b1, (j == 127 + kl) && !LOOP, 1'b0, 1'b0, -1);
      tick(1'b0, (j < 128) ? m[j] : k[j-128], rb(), (toggle && j >= 5) ? alt : sz, 1'b0, 1'b0);
    end
`ifdef SPI_AES_RESP_LOOPBACK_EN
    txd = m;
`else
    for (int g = 0; g < gap_done; g++) begin
      want(1'b1, 1'b0, 1'b0, 1'b0, -1);
      tick(1'b0, rb(), rb(), r2(), 1'b0, 1'b0);
    end
    core_result = res;
    want(1'b1, 1'b0, 1'b0, 1'b0, -1);
    tick(1'b0, rb(), rb(), r2(), 1'b1, 1'b0);
    txd = res;
`endif
    for (int g = 0; g < gap_mode; g++) begin
      want(1'b1, 1'b0, 1'b0, 1'b0, -1);
      tick(1'b0, rb(), 1'b0, r2(), 1'b0, 1'b0);
    end
    core_result = r128();
    for (int t = 0; t < 128; t++) begin
      if (t == rst_at) begin
        want(1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(1'b0, rb(), rb(), sz, 1'b0, 1'b1);
        want(1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(1'b1, rb(), rb(), sz, 1'b0, 1'b0);
        return;
      end
      want(1'b1, 1'b0, txd[t], 1'b0, t);
      tick(1'b0, rb(), (t == 0) ? 1'b1 : rb(), r2(), rb(), 1'b0);
    end
    for (int d = 0; d < 3; d++) begin
      want(1'b1, 1'b0, 1'b0, 1'b0, -1);
      tick(1'b0, rb(), rb(), r2(), 1'b0, 1'b0);
    end
    idle(2);
  endtask

  task automatic run_err(input int n);
    fclk = 0; start_cnt = 0;
    cur_err = 1'b1;
    want(1'b1, 1'b0, 1'b0, 1'b1, -1);
    tick(1'b0, rb(), rb(), 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      want(1'b1, 1'b0, 1'b0, 1'b1, -1);
      tick(1'b0, rb(), rb(), r2(), rb(), 1'b0);
    end
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] msg1, key1, res1;
    logic [255:0] key256;
    logic [191:0] key192;
    cs = 1'b1; mosi = 1'b0; mode = 1'b0; size = 2'b00; core_done = 1'b0; reset = 1'b1;
    core_result = '0;
    msg1   = 128'h3243f6a8885a308d313198a2e0370734;
    key1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    res1   = 128'h3925841d02dc09fbdc118597196a0b32;
    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

    want(1'b0, 1'b0, 1'b0, 1'b0, -1);
    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    chk_en = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    chk("rst_core_msg", 256'(core_msg), 256'd0);
    chk("rst_core_key", core_key, 256'd0);
    chk("rst_core_size", 256'(core_size), 256'd0);
    idle(3);

    run_frame(msg1, 256'(key1), 2'b00, res1, -1, 1'b0, 3, 4, -1);
`ifdef SPI_AES_RESP_LOOPBACK_EN
    chk("loop_start_cnt", 256'(start_cnt), 256'd0);
    chk("loop_miso_stream", 256'(got_res), 256'(msg1));
`else
    chk("t128_start_clk", 256'(start_at), 256'd256);
    chk("t128_start_cnt", 256'(start_cnt), 256'd1);
    chk("t128_key", got_key, 256'(key1));
    chk("t128_miso_stream", 256'(got_res), 256'(res1));
`endif

    run_frame(msg1, key256, 2'b10, r128(), -1, 1'b0, 0, 0, -1);
`ifndef SPI_AES_RESP_LOOPBACK_EN
    chk("t256_start_clk", 256'(start_at), 256'd384);
    chk("t256_key", got_key, key256);
`endif
    chk("t256_size", 256'(core_size), 256'd2);

    run_frame(r128(), {64'hdeadbeefcafef00d, key192}, 2'b01, r128(), -1, 1'b1, 5, 2, -1);
`ifndef SPI_AES_RESP_LOOPBACK_EN
    chk("t192_start_clk", 256'(start_at), 256'd320);
    chk("t192_key", got_key, 256'(key192));
`endif
    chk("t192_size", 256'(core_size), 256'd1);

    run_frame(r128(), 256'(key1), 2'b00, r128(), 60, 1'b0, 0, 0, -1);
    chk("abort_start_cnt", 256'(start_cnt), 256'd0);
    run_frame(msg1, 256'(key1), 2'b00, res1, -1, 1'b0, 1, 1, -1);
    chk("after_abort_miso", 256'(got_res), LOOP ? 256'(msg1) : 256'(res1));

    run_err(20);
    chk("err_flag_sticky", 256'(frame_err), 256'd1);
    chk("err_start_cnt", 256'(start_cnt), 256'd0);
    run_frame(r128(), {r128(), r128()}, 2'b00, r128(), -1, 1'b0, 2, 2, -1);
    chk("err_cleared", 256'(frame_err), 256'd0);

    run_frame(r128(), {r128(), r128()}, 2'b10, r128(), -1, 1'b0, 1, 1, 50);
    chk("midtx_rst_key", core_key, 256'd0);
    chk("midtx_rst_msg", 256'(core_msg), 256'd0);
    idle(2);

    for (int f = 0; f < 8; f++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(2, 0));
      run_frame(r128(), {r128(), r128()}, sz, r128(),
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(127, 0)) : -1,
                rb(), int'($urandom_range(5, 0)), int'($urandom_range(5, 0)), -1);
      idle(int'($urandom_range(3, 0)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_aes_responder.md
Name: spi_aes_responder

Overview:
- SPI-side responder for the AES test system, at the far end of the SPI link from the bit-banging initiator.
- While cs is low, deserialises a 128-bit message followed by a 128/192/256-bit key from mosi.
- Hands message and key to the AES core over a start/done handshake.
- When the initiator raises mode, serialises the 128-bit core result back on miso.
- Clocked by the same divided shift clock as the initiator, so one mosi bit is sampled per clk edge.

Parameters:
- MSG_W, 128, message and result width in bits.
- KEY_MAX_W, 256, widest key supported; core_key port width.

Ports:
- clk  in  1  shift clock (same clock the initiator shifts on)
- reset  in  1  synchronous, active-high reset
- cs  in  1  chip select, active low; a frame runs only while low
- mosi  in  1  serial data from initiator, LSB first
- mode  in  1  0 = receive phase, 1 = initiator requests the result
- size  in  2  key size: 00 = 128, 01 = 192, 10 = 256, 11 = illegal
- miso  out  1  serial result to initiator, LSB first
- core_start  out  1  one-cycle pulse; core_msg and core_key are valid
- core_msg  out  MSG_W  received message
- core_key  out  KEY_MAX_W  received key, right-aligned, upper bits zero
- core_size  out  2  size value latched for the frame
- core_done  in  1  one-cycle pulse from core; core_result is valid
- core_result  in  MSG_W  core output
- frame_err  out  1  sticky illegal-size flag, cleared at next frame start
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; shift registers and counters 0.
- States: IDLE, RX_MSG, RX_KEY, CORE, WAIT_MODE, TX, DONE, ERR.
- IDLE:
  - On cs=0, latch size into core_size, clear frame_err, and capture the first mosi bit as msg[0] in that same cycle.
  - Go to RX_MSG, or to ERR if size=11.
- RX_MSG: msg[n] <= mosi, n = 1..127. After bit 127 go to RX_KEY. The bit counter is 8 bits.
- RX_KEY:
  - key[k] <= mosi for k = 0..K-1, where K = 128/192/256 from the latched size.
  - After bit K-1, drive core_msg/core_key, pulse core_start for exactly one cycle, and go to CORE.
- Size changes after the first bit of a frame are ignored.
- CORE:
  - Wait for core_done, then latch core_result into the tx register and go to WAIT_MODE.
  - mosi bits arriving after the key are ignored.
- WAIT_MODE: miso=0. On mode=1 go to TX.
- mode=1 seen earlier than WAIT_MODE is not acted on; the tx register is only ever loaded from core_done.
- TX:
  - miso is registered. In the t-th clk after entry (t = 0..127), miso = result[t].
  - After t=127, go to DONE with miso=0.
- DONE: miso=0. Stay until cs=1, then go to IDLE.
- ERR: frame_err=1, miso=0, core_start never asserted. Stay until cs=1, then go to IDLE.
- cs=1 in any non-IDLE state aborts to IDLE next cycle:
  - counters cleared, miso=0, no core_start issued;
  - a core_done arriving after the abort is dropped;
  - frame_err keeps its value.
- reset overrides everything, including mid-frame and mid-TX.
- Latency:
  - core_start fires 128+K clks after cs falls.
  - The first result bit appears on miso the clk after mode=1 is sampled in WAIT_MODE.

Optional Feature:
- Macro: SPI_AES_RESP_LOOPBACK_EN.
- Defined:
  - CORE is skipped; the received message goes directly to the tx register.
  - The block moves RX_KEY -> WAIT_MODE. core_start stays 0 and core_done is ignored.
  - miso returns the received message, allowing link bring-up with no core.
- Undefined: normal core handshake as described in Behaviour.

Decomposition:
- Shared package (aes_spi_pkg) holds:
  - size encodings SZ_128 = 2'b00, SZ_192 = 2'b01, SZ_256 = 2'b10;
  - key-length function size -> 128/192/256;
  - MSG_W;
  - state encoding.
- Sub-module spi_shift_tx (128-bit load/shift register driving miso) is natural. The receive path stays inline.

Test Plan:
- 128-bit frame:
  - Stimulus: msg 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, size=00; stub core returns 3925841d02dc09fbdc118597196a0b32.
  - Response: core_start pulses once at clk 256; core_msg/core_key match; miso streams the result LSB first after mode=1.
- 256-bit frame:
  - Stimulus: key 000102...1e1f, size=10.
  - Response: core_start at clk 384; core_key[255:0] exact; core_size=10.
- 192-bit frame:
  - Stimulus: key 000102...1617, size=01, with size toggled to 10 mid-frame.
  - Response: core_start at clk 320; core_key[255:192]=0; core_size=01.
- Abort:
  - Stimulus: cs raised at bit 60 of the key, then a clean frame.
  - Response: no core_start for the aborted frame; the next frame completes normally.
- Illegal size:
  - Stimulus: size=11.
  - Response: frame_err=1, core_start never asserted, miso=0; frame_err clears on the next frame.
- Loopback (SPI_AES_RESP_LOOPBACK_EN defined):
  - Stimulus: any frame.
  - Response: miso bits reproduce msg 3243f6a8...0734; core_start stays 0.
